// File: rtl/soc_test_pkg.sv
// Shared encodings for the SoC test controller: FSM states, verdict status codes, default addresses.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package soc_test_pkg;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_PASS    = 2'b01;
  localparam logic [1:0] ST_FAIL    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_1000;
  localparam logic [31:0] DEF_CON_ADDR    = 32'h0000_1004;

endpackage

// File: rtl/test_con_fifo.sv
// Console byte FIFO, 8 bits wide, DEPTH entries, with a sticky overflow flag.
// Latency: a pushed byte is visible on valid/data the cycle after the push.
// Backpressure: valid/data hold until pop; a push while full (and not popping) is dropped and sets overflow.
module test_con_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       valid,
  output logic [7:0] data,
  output logic       overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          pop_ok;
  logic          accept;

  assign valid  = (count != '0);
  assign full   = (count == (PW+1)'(DEPTH));
  assign pop_ok = pop && valid;
  // a full FIFO can still take a byte when a slot is freed in the same cycle
  assign accept = push && (!full || pop_ok);
  assign data   = valid ? mem[rd_ptr] : 8'h00;

  // storage array, no reset needed since reads are masked while empty
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop_ok) begin
        count <= count + 1'b1;
      end else if (!accept && pop_ok) begin
        count <= count - 1'b1;
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_test_ctrl.sv
// Test controller beside the SoC: counted reset release, cycle-budget watchdog, TOHOST verdict snoop, retire counter.
// Latency: verdict write in cycle N -> done/status in N+1; soc_rst_n rises RST_HOLD cycles after rst release.
// Backpressure: none on the snooped bus; console bytes (SOC_TEST_CONSOLE_EN) hold until con_ready, dropped when full.
module soc_test_ctrl
  import soc_test_pkg::*;
#(
  parameter int             AW          = 32,
  parameter int             DW          = 32,
  parameter int             RST_HOLD    = 4,
  parameter int             TIMEOUT     = 1000,
  parameter int             CW          = 32,
  parameter logic [AW-1:0]  TOHOST_ADDR = AW'(DEF_TOHOST_ADDR),
  parameter logic [AW-1:0]  CON_ADDR    = AW'(DEF_CON_ADDR),
  parameter int             CON_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          soc_rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          retire,
  output logic          done,
  output logic [1:0]    status,
  output logic [DW-2:0] fail_code,
  output logic [CW-1:0] cycles,
  output logic [CW-1:0] retired,
  output logic          con_valid,
  output logic [7:0]    con_data,
  input  logic          con_ready
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          verdict_wr;

  // zero writes to TOHOST are not verdicts
  assign verdict_wr = wr_en && (wr_addr == TOHOST_ADDR) && (wr_data != '0);

  // sequencer/watchdog FSM with all status outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      soc_rst_n <= 1'b0;
      done      <= 1'b0;
      status    <= ST_RUN;
      fail_code <= '0;
      cycles    <= '0;
      retired   <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HW'(RST_HOLD - 1)) begin
            state     <= S_RUN;
            soc_rst_n <= 1'b1;
          end
        end
        S_RUN: begin
          // the cycle carrying the verdict/timeout still counts as a RUN cycle
          cycles <= cycles + 1'b1;
          if (retire) begin
            retired <= retired + 1'b1;
          end
          if (verdict_wr) begin
            done      <= 1'b1;
            soc_rst_n <= 1'b0;
            if (wr_data == DW'(1)) begin
              state  <= S_PASS;
              status <= ST_PASS;
            end else begin
              state     <= S_FAIL;
              status    <= ST_FAIL;
              fail_code <= wr_data[DW-1:1];
            end
          end else if (cycles == CW'(TIMEOUT - 1)) begin
            done      <= 1'b1;
            soc_rst_n <= 1'b0;
            state     <= S_TIMEOUT;
            status    <= ST_TIMEOUT;
          end
        end
        default: begin
          // terminal states hold everything until rst
          state <= state;
        end
      endcase
    end
  end

`ifdef SOC_TEST_CONSOLE_EN
  logic con_push;
  logic con_overflow;
  logic unused_sig;

  assign con_push   = (state == S_RUN) && wr_en && (wr_addr == CON_ADDR);
  assign unused_sig = con_overflow;

  test_con_fifo #(
    .DEPTH(CON_DEPTH)
  ) u_con (
    .clk      (clk),
    .rst      (rst),
    .push     (con_push),
    .push_data(wr_data[7:0]),
    .pop      (con_ready),
    .valid    (con_valid),
    .data     (con_data),
    .overflow (con_overflow)
  );
`else
  logic unused_sig;

  assign con_valid  = 1'b0;
  assign con_data   = 8'h00;
  assign unused_sig = ^{con_ready, CON_ADDR, CON_DEPTH[0]};
`endif

endmodule

// File: tb/tb_soc_test_ctrl.sv
// Directed bench for soc_test_ctrl with RST_HOLD=4, TIMEOUT=50; console checks only when SOC_TEST_CONSOLE_EN is defined.
// Latency: inputs driven on negedge, outputs sampled on negedge.
// Backpressure: console drain exercised through con_ready.
module tb_soc_test_ctrl;

  logic        clk;
  logic        rst;
  logic        soc_rst_n;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        retire;
  logic        done;
  logic [1:0]  status;
  logic [30:0] fail_code;
  logic [31:0] cycles;
  logic [31:0] retired;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  int checks;
  int errors;
  int pulses;

  soc_test_ctrl #(
    .RST_HOLD(4),
    .TIMEOUT (50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .soc_rst_n(soc_rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .retire   (retire),
    .done     (done),
    .status   (status),
    .fail_code(fail_code),
    .cycles   (cycles),
    .retired  (retired),
    .con_valid(con_valid),
    .con_data (con_data),
    .con_ready(con_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    wr_en   = 1'b0;
    wr_addr = 32'h0;
    wr_data = 32'h0;
    retire  = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  // assert rst, check reset values, release and check the 4-cycle hold; ends in RUN cycle 1
  task automatic reset_seq(input string tag);
    @(negedge clk);
    rst       = 1'b0;
    con_ready = 1'b0;
    idle_bus();
    #2;
    chk({tag, "_rst_soc_rst_n"}, soc_rst_n, 0);
    chk({tag, "_rst_done"}, done, 0);
    chk({tag, "_rst_status"}, status, 0);
    chk({tag, "_rst_cycles"}, cycles, 0);
    chk({tag, "_rst_retired"}, retired, 0);
    chk({tag, "_rst_fail_code"}, fail_code, 0);
    chk({tag, "_rst_con_valid"}, con_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    // verdict write during HOLD must be ignored
    bus_write(32'h1000, 32'h1);
    chk({tag, "_hold_c1"}, soc_rst_n, 0);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("%s_hold_c%0d", tag, k), soc_rst_n, 0);
    end
    @(negedge clk);
    idle_bus();
    chk({tag, "_run_c5_soc_rst_n"}, soc_rst_n, 1);
    chk({tag, "_run_c5_status"}, status, 0);
    chk({tag, "_run_c5_cycles"}, cycles, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    con_ready = 1'b0;
    idle_bus();

    // ---------------- pass ----------------
    reset_seq("pass");
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      retire = (i % 3 == 0);
      if (i == 5) bus_write(32'h1000, 32'h0);  // zero verdict ignored
      else idle_bus_keep_retire();
      @(negedge clk);
    end
    chk("pass_pre_status", status, 0);
    chk("pass_pre_done", done, 0);
    chk("pass_pre_cycles", cycles, 20);
    bus_write(32'h1000, 32'h1);
    retire = 1'b1;
    @(negedge clk);
    idle_bus();
    retire = 1'b1;
    chk("pass_done", done, 1);
    chk("pass_status", status, 1);
    chk("pass_soc_rst_n", soc_rst_n, 0);
    chk("pass_cycles", cycles, 21);
    chk("pass_retired", retired, 8);
    repeat (3) @(negedge clk);
    retire = 1'b0;
    chk("pass_cycles_frozen", cycles, 21);
    chk("pass_retired_frozen", retired, 8);
    chk("pass_status_sticky", status, 1);

    // ---------------- fail ----------------
    reset_seq("fail");
    repeat (3) @(negedge clk);
    bus_write(32'h1000, 32'h0000_0007);
    @(negedge clk);
    idle_bus();
    chk("fail_status", status, 2);
    chk("fail_code", fail_code, 3);
    chk("fail_done", done, 1);
    chk("fail_cycles", cycles, 4);
    bus_write(32'h1000, 32'h1);
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    chk("fail_sticky_status", status, 2);
    chk("fail_sticky_code", fail_code, 3);

    // ---------------- timeout ----------------
    reset_seq("to");
    repeat (49) @(negedge clk);
    chk("to_c50_status", status, 0);
    chk("to_c50_done", done, 0);
    chk("to_c50_cycles", cycles, 49);
    @(negedge clk);
    chk("to_done", done, 1);
    chk("to_status", status, 3);
    chk("to_cycles", cycles, 50);
    chk("to_soc_rst_n", soc_rst_n, 0);

    // ---------------- verdict on last cycle beats timeout ----------------
    reset_seq("last");
    repeat (49) @(negedge clk);
    bus_write(32'h1000, 32'h1);
    @(negedge clk);
    idle_bus();
    chk("last_status", status, 1);
    chk("last_cycles", cycles, 50);

    // ---------------- reset mid-RUN ----------------
    reset_seq("mid");
    for (int i = 0; i < 10; i++) begin
      retire = 1'b1;
      @(negedge clk);
    end
    retire = 1'b0;
    chk("mid_cycles_before", cycles, 10);
    chk("mid_retired_before", retired, 10);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_async_soc_rst_n", soc_rst_n, 0);
    chk("mid_async_cycles", cycles, 0);
    chk("mid_async_retired", retired, 0);
    chk("mid_async_status", status, 0);
    reset_seq("mid_again");
    repeat (2) @(negedge clk);
    chk("mid_again_cycles", cycles, 2);

    // ---------------- console ----------------
    reset_seq("con");
`ifdef SOC_TEST_CONSOLE_EN
    bus_write(32'h1004, 32'h0000_0048);
    @(negedge clk);
    bus_write(32'h1004, 32'h0000_0069);
    @(negedge clk);
    idle_bus();
    chk("con_h_valid", con_valid, 1);
    chk("con_h_data", con_data, 8'h48);
    @(negedge clk);
    chk("con_h_hold", con_data, 8'h48);
    con_ready = 1'b1;
    @(negedge clk);
    chk("con_i_valid", con_valid, 1);
    chk("con_i_data", con_data, 8'h69);
    @(negedge clk);
    chk("con_empty", con_valid, 0);
    con_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_write(32'h1004, 32'h10 + i);
      @(negedge clk);
    end
    idle_bus();
    chk("con_overflow", dut.u_con.overflow, 1);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("con_drain_%0d", i), {con_valid, con_data}, {1'b1, 8'h10 + 8'(i)});
      @(negedge clk);
    end
    chk("con_drained", con_valid, 0);
    con_ready = 1'b0;
`else
    bus_write(32'h1004, 32'h0000_0048);
    con_ready = 1'b1;
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    chk("con_off_valid", con_valid, 0);
    chk("con_off_data", con_data, 0);
    chk("con_off_status", status, 0);
    con_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // clear the bus write but leave the retire input as set by the caller
  task automatic idle_bus_keep_retire();
    wr_en   = 1'b0;
    wr_addr = 32'h0;
    wr_data = 32'h0;
  endtask

endmodule

// File: doc/soc_test_ctrl.md
Name: soc_test_ctrl

Overview:
- Reusable, parametrised test-control block instantiated beside riscv_soc_top in simulation and FPGA bring-up builds.
- Replaces fixed-delay reset release and fixed timeout with a counted reset sequencer and a cycle-budget watchdog.
- Adds pass/fail detection by snooping core data-bus writes to a TOHOST address, plus a retired-instruction counter.
- Exposes the final verdict as registered status outputs.

Parameters:
- AW, 32, snooped bus address width
- DW, 32, snooped bus data width
- RST_HOLD, 4, cycles soc_rst_n stays asserted after rst deasserts (>=1)
- TIMEOUT, 1000, cycle budget in RUN before TIMEOUT (>=1)
- CW, 32, width of cycle and retire counters
- TOHOST_ADDR, 32'h0000_1000, verdict write address
- CON_ADDR, 32'h0000_1004, console write address
- CON_DEPTH, 8, console FIFO depth (power of 2)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- soc_rst_n  out  1  reset to SoC, active-low, released synchronously
- wr_en  in  1  core data-bus write strobe, one beat per cycle
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- retire  in  1  one pulse per retired instruction
- done  out  1  verdict reached, sticky
- status  out  2  00 running, 01 pass, 10 fail, 11 timeout
- fail_code  out  DW-1  wr_data[DW-1:1] of the failing write
- cycles  out  CW  RUN cycles elapsed
- retired  out  CW  retire pulses counted in RUN
- con_valid  out  1  console byte available
- con_data  out  8  console byte
- con_ready  in  1  console byte consumed

Behaviour:
- Reset: one clock clk; reset rst is asynchronous and active-low. While rst=0: state=HOLD, soc_rst_n=0, done=0, status=00, fail_code=0, cycles=0, retired=0, con_valid=0, con_data=0, FIFO empty.
- States: HOLD, RUN, PASS, FAIL, TIMEOUT.
- HOLD: hold counter increments each cycle after rst rises. At count RST_HOLD-1, move to RUN. soc_rst_n goes to 1 on the first RUN cycle (registered output).
- RUN: cycles increments every cycle. retired increments when retire=1. Bus snooping is ignored outside RUN.
- Verdict writes: a write with wr_en=1 and wr_addr==TOHOST_ADDR.
  - wr_data==1: next state PASS, status=01.
  - Nonzero and !=1: next state FAIL, status=10, fail_code=wr_data[DW-1:1].
  - wr_data==0: ignored.
- Timeout: when cycles==TIMEOUT-1 and no verdict write occurs that cycle, next state TIMEOUT, status=11.
  - A verdict write in the same cycle takes precedence over timeout.
- Terminal states: PASS, FAIL and TIMEOUT are sticky until rst.
  - On entry: done=1 and soc_rst_n=0, so the SoC is held in reset.
  - cycles and retired freeze at their last RUN values.
- Counters wrap modulo 2^CW with no saturation. TIMEOUT < 2^CW is a legal-configuration requirement.
- Latency: verdict write in cycle N -> done/status visible in cycle N+1.
- rst asserted at any point, including mid-RUN, returns immediately to the reset values above.

Optional Feature:
- Macro SOC_TEST_CONSOLE_EN.
- Defined:
  - In RUN, a write with wr_addr==CON_ADDR pushes wr_data[7:0] into a CON_DEPTH FIFO.
  - Output handshake: con_valid/con_data hold steady until con_ready. A pop occurs when con_valid && con_ready.
  - Push and pop in the same cycle are both allowed when FIFO is non-empty; occupancy is unchanged.
  - Push when full drops the byte; an internal overflow flag sets and is sticky until rst.
  - The FIFO keeps draining in terminal states.
- Undefined: console writes are ignored, con_valid=0, con_data=0, and con_ready is unused.

Decomposition:
- Package soc_test_pkg holds:
  - state encoding (HOLD/RUN/PASS/FAIL/TIMEOUT)
  - status codes ST_RUN=2'b00, ST_PASS=2'b01, ST_FAIL=2'b10, ST_TIMEOUT=2'b11
  - default TOHOST/CON addresses
- One sub-module: test_con_fifo, a synchronous FIFO with width 8, depth CON_DEPTH, and an overflow flag. It is instantiated only under SOC_TEST_CONSOLE_EN.

Test Plan:
- Reset sequencing: release rst at t0 with RST_HOLD=4 -> soc_rst_n=0 for 4 cycles, 1 on cycle 5; status=00.
- Pass: after 20 RUN cycles, write 32'h1 to 32'h1000 -> next cycle done=1, status=01, soc_rst_n=0, cycles=21, retired equals pulses driven.
- Fail: write 32'h0000_0007 to 32'h1000 -> status=10, fail_code=3. A later write of 32'h1 leaves status=10.
- Timeout: TIMEOUT=50, no verdict -> done=1, status=11 on RUN cycle 51, cycles=50. A verdict write on the last cycle instead gives PASS.
- Reset mid-operation: assert rst in RUN at cycle 10 -> all outputs return to reset values at once; a fresh HOLD/RUN sequence follows.
- Console (SOC_TEST_CONSOLE_EN): write "H","i" to 32'h1004 with con_ready=0, then con_ready=1 -> bytes 8'h48 then 8'h69. Ten pushes with depth 8 and con_ready=0 -> first 8 kept, overflow=1.
